// File: rtl/multdiv_sequencer_if.sv
// Bus between the multiply/divide sequencer and its environment:
// start pulses, operands, the counter's count/clear pair and the result strobe.
interface multdiv_sequencer_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  count;
  logic        counter_clear;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  dbg_state;

  // Start is a single-cycle pulse with no back-pressure; data_resultRDY is a
  // one-cycle strobe qualifying data_result/data_exception, with no ready return.
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, count,
    input  counter_clear, data_result, data_exception, data_resultRDY, dbg_state
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, count,
    output counter_clear, data_result, data_exception, data_resultRDY, dbg_state
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Booth multiply / restoring divide iteration engine, one step per clock.
// Define MULTDIV_EARLY_DIV0_EN to finish a divide-by-zero in the start cycle.
module multdiv_sequencer #(
  parameter bit MULT_PRIORITY = 1'b1
) (
  input logic               clock,
  input logic               reset,
  multdiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] acc;        // Booth A, or divide partial remainder
  logic [31:0] q;          // Booth Q, or dividend/quotient shift register
  logic        qm1;
  logic [31:0] m;          // multiplicand, or divisor magnitude
  logic        neg_q;
  logic        b_zero;
  logic        iter_seen;
  logic [31:0] result_q;
  logic        exc_q;

  logic        start, pick_mult, last_iter, early_div0;
  logic [31:0] op_a_mag, op_b_mag;
  logic [32:0] booth_sum;
  logic [31:0] mul_acc_n, mul_q_n;
  logic        mul_exc;
  logic [32:0] div_shift, div_diff;
  logic [31:0] div_r_n, div_q_n, div_quot;

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign pick_mult = bus.ctrl_MULT & (MULT_PRIORITY | ~bus.ctrl_DIV);
  assign last_iter = iter_seen && (bus.count == 5'd31);
  assign op_a_mag  = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
  assign op_b_mag  = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_EARLY_DIV0_EN
  assign early_div0 = start & ~pick_mult & (bus.data_operandB == 32'd0);
`else
  assign early_div0 = 1'b0;
`endif

  // A is widened to 33 bits for the add so that a 0x80000000 multiplicand
  // cannot overflow; the shifted result always fits back into 32 bits.
  always_comb begin
    booth_sum = {acc[31], acc};
    case ({q[0], qm1})
      2'b01:   booth_sum = {acc[31], acc} + {m[31], m};
      2'b10:   booth_sum = {acc[31], acc} - {m[31], m};
      default: booth_sum = {acc[31], acc};
    endcase
  end

  assign mul_acc_n = booth_sum[32:1];
  assign mul_q_n   = {booth_sum[0], q[31:1]};
  assign mul_exc   = (mul_acc_n != {32{mul_q_n[31]}});

  assign div_shift = {acc, q[31]};
  assign div_diff  = div_shift - {1'b0, m};
  assign div_r_n   = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
  assign div_q_n   = {q[30:0], ~div_diff[32]};
  assign div_quot  = b_zero ? 32'd0 : (neg_q ? -div_q_n : div_q_n);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; a start in any state restarts cleanly
  always_comb begin
    state_n = state;
    if (early_div0) begin
      state_n = DONE;
    end else if (start) begin
      state_n = pick_mult ? MULT : DIV;
    end else begin
      case (state)
        MULT, DIV: if (last_iter) state_n = DONE;
        DONE:      state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.counter_clear  = start | (state == IDLE) | (state == DONE);
    bus.data_resultRDY = (state == DONE);
    bus.data_result    = result_q;
    bus.data_exception = exc_q;
    bus.dbg_state      = state;
  end

  // Datapath and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= 32'd0;
      q         <= 32'd0;
      qm1       <= 1'b0;
      m         <= 32'd0;
      neg_q     <= 1'b0;
      b_zero    <= 1'b0;
      iter_seen <= 1'b0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
    end else if (start) begin
      acc       <= 32'd0;
      qm1       <= 1'b0;
      iter_seen <= 1'b0;
      neg_q     <= bus.data_operandA[31] ^ bus.data_operandB[31];
      b_zero    <= (bus.data_operandB == 32'd0);
      if (pick_mult) begin
        q <= bus.data_operandB;
        m <= bus.data_operandA;
      end else begin
        q <= op_a_mag;
        m <= op_b_mag;
      end
      if (early_div0) begin
        result_q <= 32'd0;
        exc_q    <= 1'b1;
      end
    end else if (state == MULT) begin
      acc       <= mul_acc_n;
      q         <= mul_q_n;
      qm1       <= q[0];
      iter_seen <= 1'b1;
      if (last_iter) begin
        result_q <= mul_q_n;
        exc_q    <= mul_exc;
      end
    end else if (state == DIV) begin
      acc       <= div_r_n;
      q         <= div_q_n;
      iter_seen <= 1'b1;
      if (last_iter) begin
        result_q <= div_quot;
        exc_q    <= b_zero;
      end
    end
  end

endmodule
